// File: rtl/set_scan_counter.sv
// set_scan_counter: sweeps a GRID x GRID lattice and counts points meeting a circle-set membership rule (SET_DUAL_POINT_EN: two points per cycle)
module set_scan_counter #(
   parameter int GRID    = 8,
   parameter int NCIRC   = 3,
   parameter int COORD_W = 4,
   parameter int RAD_W   = 4,
   parameter int CNT_W   = $clog2(GRID*GRID+1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic [NCIRC*2*COORD_W-1:0] central,
   input  logic [NCIRC*RAD_W-1:0]     radius,
   input  logic [2:0]                 mode,
   output logic                       busy,
   output logic                       valid,
   output logic [CNT_W-1:0]           candidate
);
   localparam int DW = COORD_W + 1;
   localparam int SW = 2*DW + 1;
   localparam int RW = 2*RAD_W;
   localparam int CW = SW > RW ? SW : RW;
`ifdef SET_DUAL_POINT_EN
   localparam int STEP = 2;
`else
   localparam int STEP = 1;
`endif
   localparam logic [COORD_W-1:0] XL = COORD_W'(GRID - STEP + 1);
   localparam logic [COORD_W-1:0] YL = COORD_W'(GRID);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t                     state, state_n;
   logic [NCIRC*2*COORD_W-1:0] cen_q;
   logic [NCIRC*RAD_W-1:0]     rad_q;
   logic [2:0]                 mode_q;
   logic [COORD_W-1:0]         x, y;
   logic [CNT_W-1:0]           acc, add;
   logic                       cap, last, h0;

   function automatic logic [NCIRC-1:0] member(
      input logic [COORD_W-1:0]       px,
      input logic [COORD_W-1:0]       py,
      input logic [NCIRC*2*COORD_W-1:0] c,
      input logic [NCIRC*RAD_W-1:0]     r
   );
      logic [COORD_W-1:0]  cx, cy;
      logic [RAD_W-1:0]    ri;
      logic signed [DW-1:0] dx, dy;
      logic [2*DW-1:0]     sx, sy;
      logic [SW-1:0]       d2;
      logic [RW-1:0]       r2;
      member = '0;
      for (int i = 0; i < NCIRC; i++) begin
         cx = c[(NCIRC-i)*2*COORD_W-1 -: COORD_W];
         cy = c[(NCIRC-i)*2*COORD_W-COORD_W-1 -: COORD_W];
         ri = r[(NCIRC-i)*RAD_W-1 -: RAD_W];
         dx = $signed({1'b0, px}) - $signed({1'b0, cx});
         dy = $signed({1'b0, py}) - $signed({1'b0, cy});
         sx = dx * dx;
         sy = dy * dy;
         d2 = {1'b0, sx} + {1'b0, sy};
         r2 = ri * ri;
         member[i] = CW'(d2) <= CW'(r2);
      end
   endfunction

   function automatic logic hit(input logic [2:0] md, input logic [NCIRC-1:0] m);
      hit = md == 3'd0 ? m[0] :
            md == 3'd1 ? m[0] | m[1] :
            md == 3'd2 ? m[0] ^ m[1] :
            md == 3'd3 ? $countones(m) == 2 :
            md == 3'd4 ? &m :
            md == 3'd5 ? |m : 1'b0;
   endfunction

   // point evaluation and per-cycle increment
`ifdef SET_DUAL_POINT_EN
   logic h1;
   always_comb begin
      h0  = hit(mode_q, member(x, y, cen_q, rad_q));
      h1  = hit(mode_q, member(x + COORD_W'(1), y, cen_q, rad_q));
      add = CNT_W'(h0) + CNT_W'(h1);
   end
`else
   always_comb begin
      h0  = hit(mode_q, member(x, y, cen_q, rad_q));
      add = CNT_W'(h0);
   end
`endif

   // next-state logic: capture only from IDLE, finish on the last lattice step
   always_comb begin
      cap     = state == IDLE && en;
      last    = state == SCAN && x == XL && y == YL;
      state_n = cap ? SCAN : last ? DONE : state == DONE ? IDLE : state;
   end

   // state register
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else      state <= state_n;

   // operand capture, lattice walk, accumulation and result/handshake registers
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         cen_q     <= '0;
         rad_q     <= '0;
         mode_q    <= '0;
         x         <= '0;
         y         <= '0;
         acc       <= '0;
         busy      <= 1'b0;
         valid     <= 1'b0;
         candidate <= '0;
      end else begin
         busy  <= state_n != IDLE;
         valid <= state_n == DONE;
         if (cap) begin
            cen_q  <= central;
            rad_q  <= radius;
            mode_q <= mode;
            x      <= COORD_W'(1);
            y      <= COORD_W'(1);
            acc    <= '0;
         end else if (state == SCAN) begin
            acc <= acc + add;
            x   <= x == XL ? COORD_W'(1) : x + COORD_W'(STEP);
            y   <= x == XL ? y + COORD_W'(1) : y;
         end
         if (last) candidate <= acc + add;
      end
endmodule

// File: doc/set_scan_counter.md
# set_scan_counter

Parametrised successor to the grid-coverage SET engine. It sweeps a GRID×GRID lattice of integer points and counts those satisfying a set-membership condition over NCIRC circles. Width, grid size and circle count are generalised, a 3-bit mode field replaces the original 2-bit one, and an optional dual-point datapath halves latency. It sits behind the same en/busy/valid handshake as its predecessor, so existing pattern benches drive it unchanged apart from field widths.

## Interface
- GRID, 8: lattice dimension; points x,y ∈ 1..GRID; power of two, 2..16; requires GRID ≤ 2^COORD_W−1.
- NCIRC, 3: number of circles, 2..8.
- COORD_W, 4: bits per centre coordinate (unsigned).
- RAD_W, 4: bits per radius (unsigned).
- CNT_W, $clog2(GRID*GRID+1): candidate width.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  start request; sampled only when busy=0.
- central  in  NCIRC*2*COORD_W  packed {x0,y0,x1,y1,…}; circle 0 in the MSBs.
- radius  in  NCIRC*RAD_W  packed {r0,r1,…}; circle 0 in the MSBs.
- mode  in  3  membership function; sampled with en.
- busy  out  1  engine occupied.
- valid  out  1  one-cycle result strobe.
- candidate  out  CNT_W  point count; held between results.

## Operation
- The engine captures central, radius and mode into registers on the edge where en=1 and the state is IDLE. It ignores en at all other times.
- States:
  - IDLE → SCAN on capture.
  - SCAN → DONE after the last point.
  - DONE → IDLE unconditionally.
- SCAN walks y=1..GRID (outer loop) and x=1..GRID (inner loop), evaluating one point per cycle. The accumulator clears on capture.
- Membership of point p in circle i: (x−xi)²+(y−yi)² ≤ ri².
  - Compute differences at COORD_W+1 bits signed.
  - Compute each square at 2*(COORD_W+1) bits.
  - Compute the sum at 2*(COORD_W+1)+1 bits.
  - Compute r² at 2*RAD_W bits.
  - All comparisons are unsigned and must not truncate.
- Let m = NCIRC-bit membership vector and pc = popcount(m).
  - 000: m[0].
  - 001: m[0]|m[1].
  - 010: m[0]^m[1].
  - 011: pc==2 (exactly two circles).
  - 100: all circles (&m).
  - 101: any circle (|m).
  - 110, 111: reserved; the count is 0.
- Radius 0 covers only the centre point, and only if the centre lies on the lattice. Centres off-lattice (coordinate 0 or >GRID) are legal; only on-lattice points count.
- In DONE, candidate is loaded with the final count and valid=1.

## Timing
- Reset values: busy=0, valid=0, candidate=0, state=IDLE, accumulator=0.
- Reset asserted mid-scan aborts immediately. No valid is produced, and the previous candidate is lost (it returns to 0).
- busy rises on the edge after capture and stays high through SCAN and DONE. It falls on the edge leaving DONE, so busy=0 in the cycle after valid.
- Latency without the config macro: SCAN lasts GRID² cycles, and valid is high in cycle GRID²+1 after the capture edge (65 for GRID=8).
- The earliest next capture is the first edge with busy=0, i.e. back-to-back operation costs one idle cycle.
- candidate changes only on the DONE-entry edge or on reset.

## Configuration
- SET_DUAL_POINT_EN defined: two datapaths evaluate (x, y) and (x+1, y) each SCAN cycle, and the accumulator adds 0..2.
  - SCAN lasts GRID²/2 cycles; valid arrives at cycle GRID²/2+1 (33 for GRID=8).
  - Results are identical to the single-point build.
- SET_DUAL_POINT_EN undefined: a single datapath evaluates one point per cycle, with timing as above.

## Test plan
All scenarios use GRID=8, NCIRC=3, COORD_W=4, RAD_W=4.
- Mode 000, A=(4,4) r=2 → valid 65 cycles after capture (33 with macro), candidate=13, busy low the following cycle.
- Mode 001, A=(1,1) r=1, B=(8,8) r=1 → candidate=6 (off-lattice neighbours excluded).
- Mode 010, A=B=(4,4) r=2 → 0. Mode 101 with the same circles plus C=(0,0) r=0 → 13.
- Mode 011, A=B=(4,4) r=2, C=(4,4) r=0 → 12. Mode 100 with C r=1 → 5. Mode 110 → 0.
- Pulse en at cycles 5 and 40 of a running scan → both pulses ignored, single valid, candidate unchanged from the expected value.
- Assert rst low at scan cycle 20 → busy=0, valid=0, candidate=0 asynchronously. Release and restart mode 000 case → candidate=13.
